// File: rtl/arp_cache_table_if.sv
// Bus bundle between an ARP cache table and its client (learn, lookup, request, aging).
// Handshake: lookup transfers on a rising edge where lookup_valid && lookup_ready; the client
// holds lookup_ip stable while lookup_valid is high. Every other strobe is a single-cycle pulse.
interface arp_cache_table_if #(
  parameter int ENTRIES = 4
);
  localparam int CW = $clog2(ENTRIES + 1);

  logic          learn_valid;
  logic [31:0]   learn_ip;
  logic [47:0]   learn_mac;
  logic          lookup_valid;
  logic [31:0]   lookup_ip;
  logic          lookup_ready;
  logic          resp_valid;
  logic          resp_hit;
  logic [47:0]   resp_mac;
  logic          arp_rq_start;
  logic [31:0]   arp_rq_ip;
  logic          rq_fail;
  logic          age_tick;
  logic [CW-1:0] entry_count;

  modport master (
    output learn_valid, learn_ip, learn_mac, lookup_valid, lookup_ip, age_tick,
    input  lookup_ready, resp_valid, resp_hit, resp_mac, arp_rq_start, arp_rq_ip, rq_fail,
           entry_count
  );

  modport slave (
    input  learn_valid, learn_ip, learn_mac, lookup_valid, lookup_ip, age_tick,
    output lookup_ready, resp_valid, resp_hit, resp_mac, arp_rq_start, arp_rq_ip, rq_fail,
           entry_count
  );
endinterface

// File: rtl/arp_cache_table.sv
// IP-to-MAC cache with aging and LRU-by-age replacement, plus a lookup FSM that issues
// ARP requests on a miss and retries on age_tick-based timeouts.
module arp_cache_table #(
  parameter int ENTRIES    = 4,
  parameter int AGE_MAX    = 300,
  parameter int RQ_TIMEOUT = 2,
  parameter int RQ_RETRIES = 3
) (
  input  logic             aclk,
  input  logic             areset,
  arp_cache_table_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, WAIT_RQ = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [31:0]         ip_q  [ENTRIES];
  logic [31:0]         ip_d  [ENTRIES];
  logic [47:0]         mac_q [ENTRIES];
  logic [47:0]         mac_d [ENTRIES];
  logic [15:0]         age_q [ENTRIES];
  logic [15:0]         age_d [ENTRIES];
  logic [CW-1:0]       entry_count_q, entry_count_d;
  logic                lookup_ready_q, lookup_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [47:0]         resp_mac_q, resp_mac_d;
  logic                arp_rq_start_q, arp_rq_start_d;
  logic [31:0]         arp_rq_ip_q, arp_rq_ip_d;
  logic                rq_fail_q, rq_fail_d;
  logic [3:0]          retry_q, retry_d;
  logic [7:0]          tmo_q, tmo_d;

  logic                learn_en, learn_match, learn_free, lk_hit, rq_reply, tmo_done;
  logic [IW-1:0]       match_idx, free_idx, old_idx, wr_idx;
  logic [15:0]         old_age;
  logic [47:0]         lk_mac;
  logic [CW-1:0]       pop;

  // All searches look at the registered table, so a lookup never sees a same-cycle learn.
  always_comb begin
    learn_en    = bus.learn_valid && (bus.learn_ip != 32'd0);
    learn_match = 1'b0;
    match_idx   = '0;
    learn_free  = 1'b0;
    free_idx    = '0;
    old_idx     = '0;
    old_age     = age_q[0];
    lk_hit      = 1'b0;
    lk_mac      = '0;
    pop         = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (ip_q[i] == bus.learn_ip) && !learn_match) begin
        learn_match = 1'b1;
        match_idx   = IW'(i);
      end
      if (!valid_q[i] && !learn_free) begin
        learn_free = 1'b1;
        free_idx   = IW'(i);
      end
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IW'(i);
      end
      if (valid_q[i] && (ip_q[i] == bus.lookup_ip) && !lk_hit) begin
        lk_hit = 1'b1;
        lk_mac = mac_q[i];
      end
      pop = pop + CW'(valid_q[i]);
    end
    wr_idx = learn_match ? match_idx : (learn_free ? free_idx : old_idx);
  end

  // Aging first, then the learn write overrides so a learned entry always lands at age 0.
  always_comb begin
    valid_d = valid_q;
    ip_d    = ip_q;
    mac_d   = mac_q;
    age_d   = age_q;
    if (bus.age_tick) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_q[i]) begin
          if (17'(age_q[i]) + 17'd1 >= 17'(AGE_MAX)) begin
            valid_d[i] = 1'b0;
            age_d[i]   = '0;
          end else begin
            age_d[i] = age_q[i] + 16'd1;
          end
        end
      end
    end
    if (learn_en) begin
      valid_d[wr_idx] = 1'b1;
      ip_d[wr_idx]    = bus.learn_ip;
      mac_d[wr_idx]   = bus.learn_mac;
      age_d[wr_idx]   = '0;
    end
  end

  always_comb begin
    rq_reply       = learn_en && (bus.learn_ip == arp_rq_ip_q);
    tmo_done       = 9'(tmo_q) + 9'd1 >= 9'(RQ_TIMEOUT);
    state_d        = state_q;
    resp_valid_d   = 1'b0;
    resp_hit_d     = 1'b0;
    resp_mac_d     = '0;
    arp_rq_start_d = 1'b0;
    arp_rq_ip_d    = arp_rq_ip_q;
    rq_fail_d      = 1'b0;
    retry_d        = retry_q;
    tmo_d          = tmo_q;
    case (state_q)
      IDLE: begin
        retry_d = '0;
        tmo_d   = '0;
        if (bus.lookup_valid && lookup_ready_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_hit_d   = lk_hit;
          resp_mac_d   = lk_mac;
          if (!lk_hit) begin
            arp_rq_start_d = 1'b1;
            arp_rq_ip_d    = bus.lookup_ip;
          end
        end
      end
      RESP: begin
        if (resp_hit_q || rq_reply) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RQ;
          retry_d = 4'd1;
          tmo_d   = '0;
        end
      end
      WAIT_RQ: begin
        // A matching reply beats a timeout landing on the same edge.
        if (rq_reply) begin
          state_d = IDLE;
        end else if (bus.age_tick) begin
          if (!tmo_done) begin
            tmo_d = tmo_q + 8'd1;
          end else if (retry_q < 4'(RQ_RETRIES)) begin
            arp_rq_start_d = 1'b1;
            retry_d        = retry_q + 4'd1;
            tmo_d          = '0;
          end else begin
            rq_fail_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    lookup_ready_d = (state_d == IDLE);
    entry_count_d  = pop;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ip_q[i]  <= '0;
        mac_q[i] <= '0;
        age_q[i] <= '0;
      end
      entry_count_q  <= '0;
      lookup_ready_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_mac_q     <= '0;
      arp_rq_start_q <= 1'b0;
      arp_rq_ip_q    <= '0;
      rq_fail_q      <= 1'b0;
      retry_q        <= '0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      ip_q           <= ip_d;
      mac_q          <= mac_d;
      age_q          <= age_d;
      entry_count_q  <= entry_count_d;
      lookup_ready_q <= lookup_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_hit_q     <= resp_hit_d;
      resp_mac_q     <= resp_mac_d;
      arp_rq_start_q <= arp_rq_start_d;
      arp_rq_ip_q    <= arp_rq_ip_d;
      rq_fail_q      <= rq_fail_d;
      retry_q        <= retry_d;
      tmo_q          <= tmo_d;
    end
  end

  assign bus.lookup_ready = lookup_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_hit     = resp_hit_q;
  assign bus.resp_mac     = resp_mac_q;
  assign bus.arp_rq_start = arp_rq_start_q;
  assign bus.arp_rq_ip    = arp_rq_ip_q;
  assign bus.rq_fail      = rq_fail_q;
  assign bus.entry_count  = entry_count_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_arp_cache_table.sv
// Directed bench for arp_cache_table: a default instance plus an AGE_MAX=3 instance that
// shares the same stimulus, so expiry can be exercised without thousands of ticks.
module tb_arp_cache_table;
  logic       aclk = 1'b0;
  logic       areset;
  logic [1:0] dbg_state, a_dbg_state;
  int         checks = 0;
  int         failures = 0;
  int         n_start = 0;
  int         n_fail = 0;

  always #5 aclk = ~aclk;

  arp_cache_table_if #(.ENTRIES(4)) bus ();
  arp_cache_table_if #(.ENTRIES(4)) abus ();

  assign abus.learn_valid  = bus.learn_valid;
  assign abus.learn_ip     = bus.learn_ip;
  assign abus.learn_mac    = bus.learn_mac;
  assign abus.lookup_valid = bus.lookup_valid;
  assign abus.lookup_ip    = bus.lookup_ip;
  assign abus.age_tick     = bus.age_tick;

  arp_cache_table #(.ENTRIES(4), .AGE_MAX(300), .RQ_TIMEOUT(2), .RQ_RETRIES(3)) u_dut (
    .aclk(aclk), .areset(areset), .bus(bus), .dbg_state(dbg_state)
  );

  arp_cache_table #(.ENTRIES(4), .AGE_MAX(3), .RQ_TIMEOUT(2), .RQ_RETRIES(3)) u_age (
    .aclk(aclk), .areset(areset), .bus(abus), .dbg_state(a_dbg_state)
  );

  // Pulse counters for the default instance; sampled mid-cycle values, never raced by checks.
  always @(posedge aclk) begin
    if (bus.arp_rq_start) n_start++;
    if (bus.rq_fail) n_fail++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        is_lookup;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        exp_hit;
    logic [47:0] exp_mac;
    logic [2:0]  exp_count;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  logic        r_valid, r_hit, r_start, a_valid, a_hit;
  logic [47:0] r_mac, a_mac;
  logic [31:0] r_ip;
  int          s0, f0;

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_learn(input logic [31:0] ip, input logic [47:0] mac, input logic tick);
    bus.learn_valid = 1'b1;
    bus.learn_ip    = ip;
    bus.learn_mac   = mac;
    bus.age_tick    = tick;
    step();
    bus.learn_valid = 1'b0;
    bus.age_tick    = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.age_tick = 1'b1;
      step();
      bus.age_tick = 1'b0;
    end
  endtask

  task automatic do_lookup(input logic [31:0] ip);
    int n;
    n = 0;
    while (bus.lookup_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("lookup_ready_wait", 64'(bus.lookup_ready), 64'd1);
    bus.lookup_valid = 1'b1;
    bus.lookup_ip    = ip;
    step();
    bus.lookup_valid = 1'b0;
    r_valid = bus.resp_valid;
    r_hit   = bus.resp_hit;
    r_mac   = bus.resp_mac;
    r_start = bus.arp_rq_start;
    r_ip    = bus.arp_rq_ip;
    a_valid = abus.resp_valid;
    a_hit   = abus.resp_hit;
    a_mac   = abus.resp_mac;
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    repeat (n) step();
    areset = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'hC0A8010A, 48'h001122334455, 1'b0, 48'h0, 3'd1};
    vecs[1] = '{1'b1, 32'hC0A8010A, 48'h0, 1'b1, 48'h001122334455, 3'd1};
    vecs[2] = '{1'b1, 32'hC0A80114, 48'hAABBCCDDEEFF, 1'b0, 48'h0, 3'd2};
    vecs[3] = '{1'b1, 32'hC0A80114, 48'h0, 1'b1, 48'hAABBCCDDEEFF, 3'd2};
    vecs[4] = '{1'b0, 32'hC0A8010A, 48'h665544332211, 1'b0, 48'h0, 3'd2};
    vecs[5] = '{1'b1, 32'hC0A8010A, 48'h0, 1'b1, 48'h665544332211, 3'd2};
    vecs[6] = '{1'b0, 32'h00000000, 48'hDEADBEEF0000, 1'b0, 48'h0, 3'd2};
    vecs[7] = '{1'b0, 32'h0A000001, 48'h0000000000A1, 1'b0, 48'h0, 3'd3};
    vecs[8] = '{1'b0, 32'h0A000002, 48'h0000000000A2, 1'b0, 48'h0, 3'd4};
    vecs[9] = '{1'b1, 32'h0A000001, 48'h0, 1'b1, 48'h0000000000A1, 3'd4};

    areset           = 1'b1;
    bus.learn_valid  = 1'b0;
    bus.learn_ip     = '0;
    bus.learn_mac    = '0;
    bus.lookup_valid = 1'b0;
    bus.lookup_ip    = '0;
    bus.age_tick     = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_ready", 64'(bus.lookup_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
    check("rst_resp_mac", 64'(bus.resp_mac), 64'd0);
    check("rst_rq_start", 64'(bus.arp_rq_start), 64'd0);
    check("rst_rq_fail", 64'(bus.rq_fail), 64'd0);
    check("rst_rq_ip", 64'(bus.arp_rq_ip), 64'd0);
    check("rst_count", 64'(bus.entry_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    areset = 1'b0;
    step();
    check("rst_ready_after", 64'(bus.lookup_ready), 64'd1);
    check("rst_ready_after_age", 64'(abus.lookup_ready), 64'd1);

    // Table-driven learn / lookup vectors
    for (int v = 0; v < NV; v++) begin
      if (!vecs[v].is_lookup) begin
        do_learn(vecs[v].ip, vecs[v].mac, 1'b0);
        step();
      end else begin
        do_lookup(vecs[v].ip);
        check("vec_resp_valid", 64'(r_valid), 64'd1);
        check("vec_resp_hit", 64'(r_hit), 64'(vecs[v].exp_hit));
        check("vec_resp_mac", 64'(r_mac), 64'(vecs[v].exp_mac));
        if (!vecs[v].exp_hit) begin
          check("vec_rq_start", 64'(r_start), 64'd1);
          check("vec_rq_ip", 64'(r_ip), 64'(vecs[v].ip));
          step();
          check("vec_wait_state", 64'(dbg_state), 64'd2);
          do_learn(vecs[v].ip, vecs[v].mac, 1'b0);
          check("vec_reply_ready", 64'(bus.lookup_ready), 64'd1);
          check("vec_reply_nofail", 64'(bus.rq_fail), 64'd0);
          step();
        end else begin
          step();
          check("vec_resp_pulse", 64'(bus.resp_valid), 64'd0);
        end
      end
      check("vec_count", 64'(bus.entry_count), 64'(vecs[v].exp_count));
    end

    // Miss with no reply: requests after 0, 2, 4 ticks, failure at tick 6
    s0 = n_start;
    f0 = n_fail;
    do_lookup(32'h0B000001);
    check("to_hit", 64'(r_hit), 64'd0);
    check("to_start0", 64'(r_start), 64'd1);
    step();
    for (int k = 1; k <= 6; k++) begin
      ticks(1);
      check("to_start", 64'(bus.arp_rq_start), 64'((k == 2) || (k == 4)));
      check("to_fail", 64'(bus.rq_fail), 64'(k == 6));
      if (k < 6) check("to_rq_ip", 64'(bus.arp_rq_ip), 64'h0B000001);
    end
    check("to_ready", 64'(bus.lookup_ready), 64'd1);
    step();
    check("to_fail_pulse", 64'(bus.rq_fail), 64'd0);
    check("to_n_start", 64'(n_start - s0), 64'd3);
    check("to_n_fail", 64'(n_fail - f0), 64'd1);

    // Full table with ages 5,9,9,2: the new IP replaces entry 1
    do_reset(2);
    do_learn(32'h01010101, 48'h0000000000B0, 1'b0);
    do_learn(32'h02020202, 48'h0000000000B1, 1'b0);
    do_learn(32'h03030303, 48'h0000000000B2, 1'b0);
    do_learn(32'h04040404, 48'h0000000000B3, 1'b0);
    ticks(4);
    do_learn(32'h01010101, 48'h0000000000B0, 1'b0);
    ticks(3);
    do_learn(32'h04040404, 48'h0000000000B3, 1'b0);
    ticks(2);
    do_learn(32'h05050505, 48'h0000000000C5, 1'b0);
    step();
    check("repl_count", 64'(bus.entry_count), 64'd4);
    do_lookup(32'h05050505);
    check("repl_new_hit", 64'(r_hit), 64'd1);
    check("repl_new_mac", 64'(r_mac), 64'h0000000000C5);
    step();
    do_lookup(32'h01010101);
    check("repl_e0_hit", 64'(r_hit), 64'd1);
    step();
    do_lookup(32'h03030303);
    check("repl_e2_mac", 64'(r_mac), 64'h0000000000B2);
    step();
    do_lookup(32'h04040404);
    check("repl_e3_hit", 64'(r_hit), 64'd1);
    step();
    do_lookup(32'h02020202);
    check("repl_e1_gone", 64'(r_hit), 64'd0);
    check("repl_e1_rq", 64'(r_start), 64'd1);
    step();
    check("repl_wait_state", 64'(dbg_state), 64'd2);

    // Reset while waiting for a reply abandons the request
    s0 = n_start;
    f0 = n_fail;
    areset       = 1'b1;
    bus.age_tick = 1'b1;
    step();
    bus.age_tick = 1'b0;
    check("wrst_ready_low", 64'(bus.lookup_ready), 64'd0);
    step();
    areset = 1'b0;
    step();
    check("wrst_ready", 64'(bus.lookup_ready), 64'd1);
    check("wrst_count", 64'(bus.entry_count), 64'd0);
    check("wrst_rq_ip", 64'(bus.arp_rq_ip), 64'd0);
    check("wrst_state", 64'(dbg_state), 64'd0);
    ticks(3);
    step();
    check("wrst_no_start", 64'(n_start - s0), 64'd0);
    check("wrst_no_fail", 64'(n_fail - f0), 64'd0);

    // AGE_MAX=3 instance: expiry, then learn+tick in the same cycle
    do_reset(2);
    do_learn(32'h0A0A0A0A, 48'h0000000000D1, 1'b0);
    ticks(2);
    step();
    check("age_count_2t", 64'(abus.entry_count), 64'd1);
    ticks(1);
    step();
    check("age_count_3t", 64'(abus.entry_count), 64'd0);
    do_lookup(32'h0A0A0A0A);
    check("age_resp_valid", 64'(a_valid), 64'd1);
    check("age_miss", 64'(a_hit), 64'd0);
    check("age_miss_mac", 64'(a_mac), 64'd0);
    check("age_main_hit", 64'(r_hit), 64'd1);
    step();
    check("age_wait_state", 64'(a_dbg_state), 64'd2);
    ticks(1);
    do_learn(32'h0A0A0A0A, 48'h0000000000D2, 1'b1);
    check("prio_no_start", 64'(abus.arp_rq_start), 64'd0);
    check("prio_no_fail", 64'(abus.rq_fail), 64'd0);
    check("prio_ready", 64'(abus.lookup_ready), 64'd1);
    step();
    check("lt_count", 64'(abus.entry_count), 64'd1);
    ticks(2);
    step();
    check("lt_count_2t", 64'(abus.entry_count), 64'd1);
    ticks(1);
    step();
    check("lt_count_3t", 64'(abus.entry_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
